// File: rtl/alien_draw_arbiter.sv
// Shares one VGA plot port among N alien movers: each frame tick it scans the
// aliens and erases/redraws any sprite whose position or enable changed.
module alien_draw_arbiter #(
  parameter int          N        = 4,
  parameter int          SPRITE_W = 4,
  parameter int          SPRITE_H = 4,
  parameter logic [2:0]  COLOUR   = 3'b010
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [N-1:0]     alien_en,
  input  logic [8*N-1:0]   alien_x,
  input  logic [7*N-1:0]   alien_y,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             plot,
  output logic             busy,
  output logic             frame_done
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, ERASE, DRAW, DONE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          cur_en;
  logic [7:0]    cur_x;
  logic [6:0]    cur_y;
  logic [N-1:0]  shown;
  logic [7:0]    last_x [N];
  logic [6:0]    last_y [N];
  logic [7:0]    ax [N];
  logic [6:0]    ay [N];
  logic [7:0]    hold_x;
  logic [6:0]    hold_y;
  logic [2:0]    hold_c;
  logic          last_pix, last_idx, changed;
  logic [7:0]    base_x;
  logic [6:0]    base_y;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ax[i] = alien_x[8*i +: 8];
    assign ay[i] = alien_y[7*i +: 7];
  end

  assign last_pix = (col == CW'(SPRITE_W-1)) && (row == RW'(SPRITE_H-1));
  assign last_idx = (idx == IW'(N-1));
  assign changed  = !alien_en[idx] || (ax[idx] != last_x[idx]) || (ay[idx] != last_y[idx]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = SCAN;
      SCAN: begin
        if (shown[idx] && changed)          state_nxt = ERASE;
        else if (!shown[idx] && alien_en[idx]) state_nxt = DRAW;
        else                                state_nxt = last_idx ? DONE : SCAN;
      end
      ERASE: if (last_pix) state_nxt = cur_en ? DRAW : (last_idx ? DONE : SCAN);
      DRAW:  if (last_pix) state_nxt = last_idx ? DONE : SCAN;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel outputs are combinational while plotting and frozen otherwise.
  always_comb begin
    plot       = (state == ERASE) || (state == DRAW);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    base_x     = (state == ERASE) ? last_x[idx] : cur_x;
    base_y     = (state == ERASE) ? last_y[idx] : cur_y;
    vga_x      = plot ? 8'(base_x + 8'(col)) : hold_x;
    vga_y      = plot ? 7'(base_y + 7'(row)) : hold_y;
    vga_colour = (state == DRAW) ? COLOUR : (state == ERASE) ? 3'b000 : hold_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      idx    <= '0;
      col    <= '0;
      row    <= '0;
      cur_en <= 1'b0;
      cur_x  <= '0;
      cur_y  <= '0;
      shown  <= '0;
      hold_x <= '0;
      hold_y <= '0;
      hold_c <= '0;
      for (int i = 0; i < N; i++) begin
        last_x[i] <= '0;
        last_y[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      hold_x <= vga_x;
      hold_y <= vga_y;
      hold_c <= vga_colour;
      case (state)
        IDLE: if (go) idx <= '0;
        SCAN: begin
          cur_en <= alien_en[idx];
          cur_x  <= ax[idx];
          cur_y  <= ay[idx];
          col    <= '0;
          row    <= '0;
          if (state_nxt == SCAN) idx <= idx + 1'b1;
        end
        ERASE, DRAW: begin
          if (last_pix) begin
            col <= '0;
            row <= '0;
            if (state == DRAW) begin
              last_x[idx] <= cur_x;
              last_y[idx] <= cur_y;
              shown[idx]  <= 1'b1;
            end else if (!cur_en) begin
              shown[idx] <= 1'b0;
            end
            if (state_nxt == SCAN) idx <= idx + 1'b1;
          end else if (col == CW'(SPRITE_W-1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alien_draw_arbiter.sv
// Bench for alien_draw_arbiter: table frames, corner sequences and random
// frames, each checked against a pixel-list model of the frame.
module tb_alien_draw_arbiter;
  localparam int N = 4;
  localparam logic [2:0] COL = 3'b010;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           go = 1'b0;
  logic [N-1:0]   alien_en = '0;
  logic [8*N-1:0] alien_x = '0;
  logic [7*N-1:0] alien_y = '0;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           plot, busy, frame_done;

  alien_draw_arbiter #(.N(N), .SPRITE_W(4), .SPRITE_H(4), .COLOUR(COL)) dut (
    .clk(clk), .resetn(resetn), .go(go), .alien_en(alien_en),
    .alien_x(alien_x), .alien_y(alien_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit m_shown [N];
  int m_lx [N];
  int m_ly [N];
  int expq [$];

  typedef struct {
    logic [3:0] en;
    int         x0;
    int         y0;
    int         pix;
    int         done;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic int pk(int x, int y, int c);
    return ((x % 256) << 10) | ((y % 128) << 3) | c;
  endfunction

  task automatic push_sprite(input int bx, input int by, input int c);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        expq.push_back(pk(bx + k, by + r, c));
  endtask

  // The frame as a list of pixels: erase old sprite if it moved or vanished,
  // then draw it wherever it is now enabled.
  task automatic build_model();
    expq.delete();
    for (int i = 0; i < N; i++) begin
      int x, y;
      bit en;
      en = alien_en[i];
      x  = int'(alien_x[8*i +: 8]);
      y  = int'(alien_y[7*i +: 7]);
      if (m_shown[i] && (!en || x != m_lx[i] || y != m_ly[i])) begin
        push_sprite(m_lx[i], m_ly[i], 0);
        m_shown[i] = 0;
      end
      if (!m_shown[i] && en) begin
        push_sprite(x, y, int'(COL));
        m_shown[i] = 1;
        m_lx[i] = x;
        m_ly[i] = y;
      end
    end
  endtask

  task automatic run_frame(input string tag, input bit disturb,
                           output int npix, output int done_cyc, output int first_plot);
    int exp_done;
    build_model();
    exp_done = N + expq.size() + 1;
    npix = 0;
    done_cyc = -1;
    first_plot = -1;
    @(negedge clk) go = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      if (disturb && cyc == 8) begin
        go = 1'b1;
        alien_x[7:0] = 8'd50;
      end
      if (plot) begin
        if (first_plot < 0) first_plot = cyc;
        if (npix < expq.size())
          check($sformatf("%s pix%0d", tag, npix), int'({vga_x, vga_y, vga_colour}), expq[npix]);
        npix++;
      end
      if (frame_done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, " npix"}, npix, expq.size());
    check({tag, " done_cycle"}, done_cyc, exp_done);
    @(negedge clk);
    check({tag, " busy_after"}, int'(busy), 0);
  endtask

  initial begin
    vec_t tbl [6];
    int npix, dcyc, fp;

    tbl[0] = '{4'b0000, 0,  0,  0,  5};
    tbl[1] = '{4'b0001, 82, 15, 16, 21};
    tbl[2] = '{4'b0001, 83, 15, 32, 37};
    tbl[3] = '{4'b0001, 83, 15, 0,  5};
    tbl[4] = '{4'b0000, 83, 15, 16, 21};
    tbl[5] = '{4'b0000, 83, 15, 0,  5};

    #12;
    check("reset plot", int'(plot), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(frame_done), 0);
    check("reset vga", int'({vga_x, vga_y, vga_colour}), 0);
    @(negedge clk) resetn = 1'b1;

    for (int t = 0; t < 6; t++) begin
      alien_en     = tbl[t].en;
      alien_x[7:0] = 8'(tbl[t].x0);
      alien_y[6:0] = 7'(tbl[t].y0);
      run_frame($sformatf("tbl%0d", t), 1'b0, npix, dcyc, fp);
      check($sformatf("tbl%0d tbl_pix", t), npix, tbl[t].pix);
      check($sformatf("tbl%0d tbl_done", t), dcyc, tbl[t].done);
      if (tbl[t].pix > 0) check($sformatf("tbl%0d first_plot", t), fp, 2);
    end

    // go and a position change during DRAW must not disturb the frame
    alien_en = 4'b0001;
    alien_x[7:0] = 8'd10;
    alien_y[6:0] = 7'd20;
    run_frame("hold", 1'b1, npix, dcyc, fp);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold no_rescan", int'(busy), 0);
    end

    alien_x[7:0] = 8'd254;
    alien_y[6:0] = 7'd126;
    run_frame("wrap", 1'b0, npix, dcyc, fp);

    // async reset during cycle 9 of the draw that follows an erase
    alien_x[7:0] = 8'd100;
    alien_y[6:0] = 7'd50;
    @(negedge clk) go = 1'b1;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      @(negedge clk);
      go = 1'b0;
    end
    check("rst_mid plot_before", int'(plot), 1);
    check("rst_mid colour_before", int'(vga_colour), int'(COL));
    #2 resetn = 1'b0;
    #1;
    check("rst_mid plot", int'(plot), 0);
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid vga", int'({vga_x, vga_y, vga_colour}), 0);
    for (int i = 0; i < N; i++) begin
      m_shown[i] = 0;
      m_lx[i] = 0;
      m_ly[i] = 0;
    end
    @(negedge clk) resetn = 1'b1;
    run_frame("redraw", 1'b0, npix, dcyc, fp);
    check("redraw first_plot", fp, 2);
    check("redraw npix16", npix, 16);

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < N; i++) begin
        alien_en[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          alien_x[8*i +: 8] = 8'($urandom);
          alien_y[7*i +: 7] = 7'($urandom);
        end
      end
      run_frame($sformatf("rand%0d", f), 1'b0, npix, dcyc, fp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alien_draw_arbiter.md
Name: alien_draw_arbiter

Overview:
- Shares the single VGA pixel-plot port between N alien movers (x/y position sources).
- On each frame tick it scans the aliens in order. For every alien whose position or enable changed, it erases the old sprite and then draws the new one, one pixel per cycle.
- Sits between the alien mover instances and the VGA adaptor. It is the only driver of the adaptor's plot inputs.

Parameters:
- N, 4, number of alien requesters (1..8).
- SPRITE_W, 4, sprite width in pixels (1..8).
- SPRITE_H, 4, sprite height in pixels (1..8).
- COLOUR, 3'b010, draw colour. Erase colour is always 3'b000.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; one clock; asynchronous, active-low.
- go  in  1  frame tick; sampled only in IDLE.
- alien_en  in  N  per-alien enable; 0 = destroyed/absent.
- alien_x  in  8*N  alien i x position at bits [8i+7:8i].
- alien_y  in  7*N  alien i y position at bits [7i+6:7i].
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- plot  out  1  pixel write strobe, 1 pixel per cycle.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, idx=0, col=row=0.
  - All shown[i]=0; last_x/last_y registers = 0.
  - Outputs: vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, frame_done=0.
  - Reset mid-operation abandons the sprite immediately. Partially drawn pixels are not erased.
- Per-alien state: shown[i], last_x[i], last_y[i]. These record the position actually drawn.
- States: IDLE, SCAN, ERASE, DRAW, DONE.
- IDLE:
  - go=1 -> SCAN with idx=0.
  - go at any other state is ignored and not queued.
- SCAN (1 cycle per alien): sample alien_en[idx], alien_x/y[idx] into cur_en, cur_x, cur_y.
  - shown=1 and (en=0 or position differs from last) -> ERASE.
  - shown=0 and en=1 -> DRAW.
  - Otherwise (unchanged, or not shown and disabled) -> advance.
- Advance: idx==N-1 -> DONE; else idx+1 and SCAN.
- ERASE: SPRITE_W*SPRITE_H cycles, plot=1, colour 000, base = last_x/last_y[idx].
  - After the last pixel: cur_en=1 -> DRAW; else shown[idx]=0 and advance.
- DRAW: SPRITE_W*SPRITE_H cycles, plot=1, colour COLOUR, base = cur_x/cur_y.
  - After the last pixel: last_x/last_y[idx] = cur_x/cur_y, shown[idx]=1, advance.
- Pixel order is row-major, col fastest:
  - vga_x = base_x + col (mod 256); vga_y = base_y + row (mod 128). No clipping.
  - col/row reset to 0 on entry to each ERASE/DRAW.
- Input changes after the SCAN sample do not affect the sprite in progress. They are picked up next frame.
- DONE: frame_done=1 for exactly 1 cycle -> IDLE.
- plot is high only in ERASE/DRAW. vga_* hold their last values when plot=0.
- Latency and frame cost:
  - go in IDLE at cycle 0 -> first SCAN at cycle 1 -> first pixel at cycle 2.
  - Frame cost = N SCAN cycles + 16 per erase + 16 per draw (4x4 sprite) + 1 DONE cycle.

Test Plan (N=4, 4x4 sprite, COLOUR=010):
1. Reset:
   - Stimulus: assert resetn=0 without a clock edge.
   - Required: plot, busy, frame_done, vga_* all 0 immediately. go with all en=0 -> SCAN cycles 1-4, frame_done high at cycle 5, busy low at cycle 6, no plot.
2. First draw:
   - Stimulus: en=0001, alien0 at (82,15); go at cycle 0.
   - Required: plot high cycles 2-17, pixels (82,15),(83,15)..(85,18), colour 010. frame_done at cycle 21.
3. Move:
   - Stimulus: alien0 moves to (83,15); go.
   - Required: 16 erase pixels at (82..85,15..18) colour 000, then 16 draw pixels at (83..86,15..18) colour 010. frame_done at cycle 37.
   - Stimulus: next go with no change.
   - Required: no plot, frame_done at cycle 5.
4. Disable:
   - Stimulus: en -> 0000; go.
   - Required: 16 erase pixels only, no draw. The following frame has no plot.
5. Ignore and hold:
   - Stimulus: pulse go at cycle 8 during DRAW; change alien0_x at cycle 8.
   - Required: no second scan starts. Draw completes at the position sampled at cycle 1.
6. Wrap and reset:
   - Stimulus: alien at (254,126); go.
   - Required: x sequence 254,255,0,1 and y rows 126,127,0,1.
   - Stimulus: async reset at cycle 9 of the next draw.
   - Required: plot drops at once. After reset, go redraws the alien with no erase phase (plot cycles 2-17).
